// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter and its per-source FIFOs.
package cdb_arbiter_pkg;
  localparam int ROB_WIDTH = 4;
  localparam int DATA_W    = 32;
  // Producer indices on the src_* vectors
  localparam int SRC_ALU   = 0;
  localparam int SRC_LSB   = 1;
  localparam int SRC_BR    = 2;
endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-producer result FIFO; the count register separates full from empty.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_q];
  // Guards keep the FIFO consistent even if a caller misbehaves
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointer and occupancy update; flush wins over push/pop
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: occupancy decides what is valid
  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter from producer FIFOs onto one registered common data bus.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_WIDTH  = cdb_arbiter_pkg::ROB_WIDTH,
  parameter int N_SRC      = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear_signal,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [DATA_W*N_SRC-1:0]   src_value,
  input  logic [ROB_WIDTH*N_SRC-1:0] src_tag,
  output logic [N_SRC-1:0]          src_ready,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_value,
  output logic [ROB_WIDTH-1:0]      cdb_tag
);
  localparam int EW = DATA_W + ROB_WIDTH;
  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] empty, full, push, pop;
  logic [EW-1:0]    head [N_SRC];
  logic             flush, grant;
  logic [PW-1:0]    win;

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 valid_q, valid_d;
  logic [DATA_W-1:0]    value_q, value_d;
  logic [ROB_WIDTH-1:0] tag_q, tag_d;

  // Ready depends only on FIFO state and the stall, never on src_valid
  assign src_ready = {N_SRC{rdy_in}} & ~full;
  assign push      = src_valid & src_ready & {N_SRC{~clear_signal}};
  assign flush     = rdy_in & clear_signal;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .flush_i (flush),
      .din_i   ({src_value[DATA_W*g +: DATA_W], src_tag[ROB_WIDTH*g +: ROB_WIDTH]}),
      .head_o  (head[g]),
      .empty_o (empty[g]),
      .full_o  (full[g])
    );
  end

  // Pick the first non-empty FIFO scanning from rr_ptr; build next bus state
  always_comb begin
    grant    = 1'b0;
    win      = '0;
    pop      = '0;
    rr_ptr_d = rr_ptr_q;
    valid_d  = 1'b0;
    value_d  = value_q;
    tag_d    = tag_q;
    for (int k = 0; k < N_SRC; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!grant && !empty[idx]) begin
        grant = 1'b1;
        win   = PW'(idx);
      end
    end
    // A flush discards this edge's grant; rr_ptr holds
    if (grant && !clear_signal) begin
      pop[win] = rdy_in;
      valid_d  = 1'b1;
      value_d  = head[win][EW-1:ROB_WIDTH];
      tag_d    = head[win][ROB_WIDTH-1:0];
      rr_ptr_d = (win == PW'(N_SRC-1)) ? '0 : win + 1'b1;
    end
  end

  // Bus and pointer registers; a stall freezes everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q <= PW'(SRC_ALU);
      valid_q  <= 1'b0;
      value_q  <= '0;
      tag_q    <= '0;
    end else if (rdy_in) begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      value_q  <= value_d;
      tag_q    <= tag_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_value = value_q;
  assign cdb_tag   = tag_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed scoreboard bench for cdb_arbiter: stimulus queues expected broadcasts,
// a monitor pops and compares each new CDB grant.
module tb_cdb_arbiter;
  localparam int RW = 4;
  localparam int N  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rdy = 1'b1;
  logic            clr = 1'b0;
  logic [N-1:0]    sv  = '0;
  logic [32*N-1:0] sval = '0;
  logic [RW*N-1:0] stag = '0;
  logic [N-1:0]    srdy;
  logic            cv;
  logic [31:0]     cval;
  logic [RW-1:0]   ctag;

  int checks   = 0;
  int failures = 0;
  logic [35:0] exp_q [$];

  always #5 clk = ~clk;

  cdb_arbiter #(.ROB_WIDTH(RW), .N_SRC(N), .FIFO_DEPTH(2)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_signal(clr),
    .src_valid(sv), .src_value(sval), .src_tag(stag), .src_ready(srdy),
    .cdb_valid(cv), .cdb_value(cval), .cdb_tag(ctag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v,
                       input logic [31:0] a, input logic [3:0] ta,
                       input logic [31:0] b, input logic [3:0] tb,
                       input logic [31:0] c, input logic [3:0] tc);
    sv   = v;
    sval = {c, b, a};
    stag = {tc, tb, ta};
  endtask

  task automatic idle();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_bc(input logic [31:0] v, input logic [3:0] t);
    exp_q.push_back({v, t});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: a new broadcast is any edge with rdy high, out of reset, that leaves cdb_valid set
  initial begin
    logic r, rs;
    logic [35:0] e;
    forever begin
      @(posedge clk);
      r  = rdy;
      rs = rst;
      #1;
      if (!rs && r && cv) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL cdb_unexpected: got value=%0h tag=%0h with nothing expected", cval, ctag);
        end else begin
          e = exp_q.pop_front();
          if ({cval, ctag} !== e) begin
            failures++;
            $display("FAIL cdb_data: got value=%0h tag=%0h expected value=%0h tag=%0h",
                     cval, ctag, e[35:4], e[3:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst_valid", cv, 0);
    chk("rst_value", cval, 0);
    chk("rst_tag", ctag, 0);
    chk("rst_ready_rdy1", srdy, 3'b111);
    rdy = 1'b0; #1;
    chk("rst_ready_rdy0", srdy, 3'b000);
    rdy = 1'b1;
    step(); step();
    rst = 1'b0;

    // Single result from the ALU
    drive(3'b001, 32'h5, 4'd3, 0, 0, 0, 0); expect_bc(32'h5, 4'd3);
    step(); idle();
    chk("single_latency_not_early", cv, 0);
    step();
    chk("single_valid", cv, 1);
    chk("single_tag", ctag, 3);
    chk("single_value", cval, 5);
    step();
    chk("single_drop", cv, 0);

    // Round robin from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    drive(3'b111, 32'h101, 4'd1, 32'h102, 4'd2, 32'h103, 4'd3);
    expect_bc(32'h101, 1); expect_bc(32'h102, 2); expect_bc(32'h103, 3);
    step(); idle();
    step(); chk("rr_tag1", ctag, 1);
    step(); chk("rr_tag2", ctag, 2);
    step(); chk("rr_tag3", ctag, 3);
    drive(3'b111, 32'h111, 4'd10, 32'h112, 4'd11, 32'h113, 4'd12);
    expect_bc(32'h111, 10); expect_bc(32'h112, 11); expect_bc(32'h113, 12);
    step(); idle();
    step(); chk("rr2_first_src0", ctag, 10);
    step(); step();
    step(); chk("rr2_drain", cv, 0);

    // Backpressure on source 1 while 0 and 2 keep the bus busy
    expect_bc(32'hA0, 0);  expect_bc(32'hB4, 4); expect_bc(32'hC0, 12);
    expect_bc(32'hA1, 1);  expect_bc(32'hB5, 5); expect_bc(32'hC1, 13);
    expect_bc(32'hA2, 2);  expect_bc(32'hB6, 6);
    drive(3'b111, 32'hA0, 0, 32'hB4, 4, 32'hC0, 12); step();
    drive(3'b111, 32'hA1, 1, 32'hB5, 5, 32'hC1, 13); step();
    chk("bp_ready_after2", srdy, 3'b001);
    drive(3'b011, 32'hA2, 2, 32'hB6, 6, 0, 0); step();
    chk("bp_ready_after_pop", srdy, 3'b010);
    drive(3'b010, 0, 0, 32'hB6, 6, 0, 0); step();
    chk("bp_tag6_taken", srdy, 3'b100);
    idle();
    for (int i = 0; i < 6; i++) step();
    chk("bp_drain", cv, 0);

    // Flush with an ALU push on the same edge
    expect_bc(32'hD2, 2);
    drive(3'b111, 32'hD0, 0, 32'hD1, 1, 32'hD2, 2); step();
    drive(3'b111, 32'hD3, 3, 32'hD4, 4, 32'hD5, 5); step();
    chk("fl_pre_ready", srdy, 3'b100);
    drive(3'b001, 32'hEE, 14, 0, 0, 0, 0); clr = 1'b1; step();
    clr = 1'b0; idle();
    chk("fl_valid", cv, 0);
    chk("fl_ready", srdy, 3'b111);
    step(); chk("fl_push_dropped", cv, 0);
    step(); chk("fl_empty", cv, 0);

    // Stall holding tag 7 on the bus
    expect_bc(32'h77, 7); expect_bc(32'h78, 8); expect_bc(32'h79, 9);
    drive(3'b111, 32'h77, 7, 32'h78, 8, 32'h79, 9); step();
    idle(); step();
    chk("st_tag7", ctag, 7);
    rdy = 1'b0;
    drive(3'b111, 32'hDD, 13, 32'hDD, 13, 32'hDD, 13);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_hold_valid", cv, 1);
      chk("st_hold_tag", ctag, 7);
      chk("st_ready0", srdy, 3'b000);
    end
    rdy = 1'b1; idle();
    step(); chk("st_resume8", ctag, 8);
    step(); chk("st_resume9", ctag, 9);
    step(); chk("st_no_junk", cv, 0);

    // Asynchronous reset with data queued
    expect_bc(32'hE0, 14);
    drive(3'b011, 32'hE0, 14, 32'hE1, 15, 0, 0); step();
    idle(); step();
    chk("ar_pre_valid", cv, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", cv, 0);
    chk("ar_value", cval, 0);
    chk("ar_tag", ctag, 0);
    step(); step();
    rst = 1'b0;
    chk("ar_ready", srdy, 3'b111);
    expect_bc(32'h55, 5);
    drive(3'b100, 0, 0, 0, 0, 32'h55, 5); step();
    idle(); step();
    chk("ar_first_tag", ctag, 5);
    chk("ar_first_value", cval, 32'h55);
    step(); chk("ar_no_stale", cv, 0);

    step(); step();
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
